// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters, with single/two-word transfers.
// Optional build macro RAM_ARB_WRITE_PRIO_EN: pending writes win arbitration over pending reads.
module ram_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NREQ-1:0]     req_ren,
  input  logic [NREQ-1:0]     req_wen,
  input  logic [NREQ-1:0]     req_burst,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_store,
  output logic [NREQ-1:0]     req_wait,
  output logic [NREQ*DW-1:0]  req_load,
  input  logic [1:0]          ramstate,
  input  logic [DW-1:0]       ramload,
  output logic [AW-1:0]       ramaddr,
  output logic [DW-1:0]       ramstore,
  output logic                ramREN,
  output logic                ramWEN,
  output logic                grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {S_IDLE, S_XFER0, S_XFER1} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           is_write_q, is_write_d;
  logic           grant_valid_q;

  logic [NREQ-1:0] pend, cand;
  logic            found;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  next_ptr;
  logic            in_xfer, g_live, g_burst, word_done;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_store;

  // Live view of the granted requester; the RAM side follows it combinationally.
  assign in_xfer   = (state_q != S_IDLE);
  assign g_live    = req_ren[grant_id_q] | req_wen[grant_id_q];
  assign g_burst   = req_burst[grant_id_q];
  assign g_addr    = req_addr[int'(grant_id_q)*AW +: AW];
  assign g_store   = req_store[int'(grant_id_q)*DW +: DW];
  assign word_done = in_xfer & g_live & (ramstate_t'(ramstate) == ACCESS);
  assign next_ptr  = IDW'((int'(grant_id_q) + 1) % NREQ);

  assign ramREN   = in_xfer & g_live & ~is_write_q;
  assign ramWEN   = in_xfer & g_live & is_write_q;
  assign ramaddr  = in_xfer ? (g_addr + ((state_q == S_XFER1) ? AW'(4) : AW'(0))) : '0;
  assign ramstore = ramWEN ? g_store : '0;

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      logic sel;
      assign sel = in_xfer && (int'(grant_id_q) == gi);
      assign req_wait[gi] = ~(sel & word_done);
      assign req_load[gi*DW +: DW] = (sel & ramREN) ? ramload : '0;
    end
  endgenerate

  // Round-robin scan: first candidate at or after rr_ptr, wrapping.
  always_comb begin
    pend  = req_ren | req_wen;
`ifdef RAM_ARB_WRITE_PRIO_EN
    cand  = (|req_wen) ? req_wen : pend;
`else
    cand  = pend;
`endif
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && cand[(int'(rr_ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        pick  = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    is_write_d = is_write_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_id_d = pick;
          is_write_d = req_wen[pick];
          state_d    = S_XFER0;
        end
      end
      S_XFER0: begin
        if (!g_live || (word_done && !g_burst)) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_ptr;
        end else if (word_done) begin
          state_d = S_XFER1;
        end
      end
      S_XFER1: begin
        if (!g_live || word_done) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      is_write_q    <= 1'b0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      is_write_q    <= is_write_d;
      grant_valid_q <= (state_d != S_IDLE);
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares the single RAM port among `NREQ` cache/fetch requesters. It sits between the per-cache request lines and the RAM, and sequences single-word and two-word (block) transfers against the RAM `ramstate` handshake. It owns no coherence logic; it only grants, drives and completes RAM transactions fairly.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `req_ren`  in  NREQ  per-requester read request.
- `req_wen`  in  NREQ  per-requester write request. If `req_wen` and `req_ren` are both high, the request is a write.
- `req_burst`  in  NREQ  1 = two-word transfer (addr, addr+4); 0 = single word.
- `req_addr`  in  NREQ*AW  packed addresses; requester i at `[i*AW +: AW]`.
- `req_store`  in  NREQ*DW  packed write data.
- `req_wait`  out  NREQ  active-low word-done strobe per requester.
- `req_load`  out  NREQ*DW  read data; only the granted slice carries `ramload`, all others are 0.
- `ramstate`  in  2  RAM status, `ramstate_t`: FREE, BUSY, ACCESS, ERROR.
- `ramload`  in  DW  RAM read data.
- `ramaddr`  out  AW  RAM address.
- `ramstore`  out  DW  RAM write data.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `grant_valid`  out  1  a transfer is in progress.
- `grant_id`  out  $clog2(NREQ)  registered index of the granted requester.

## Operation
- States: IDLE, XFER0, XFER1.
- IDLE:
  - `pend[i] = req_ren[i] | req_wen[i]`.
  - If any `pend` is set, pick the first set bit at or after `rr_ptr`, scanning upward and wrapping modulo NREQ.
  - Register `grant_id` and `is_write`, then go to XFER0.
- XFER0:
  - Drive `ramaddr = req_addr[grant_id]`.
  - Write: `ramWEN=1`, `ramstore = req_store[grant_id]`. Read: `ramREN=1`, `req_load[grant_id] = ramload`.
  - On `ramstate==ACCESS`: `req_wait[grant_id]=0` for that cycle only. Then go to XFER1 if `req_burst[grant_id]`, else go to IDLE.
- XFER1:
  - Same as XFER0, but `ramaddr = req_addr[grant_id] + 4` (modulo 2^AW).
  - On ACCESS: `req_wait[grant_id]=0`, go to IDLE.
- On every return to IDLE: `rr_ptr <= (grant_id+1) mod NREQ`.
- FREE, BUSY and ERROR are all non-completion. The arbiter holds its outputs and stays in the current state.
- Requester withdraws (both `req_ren` and `req_wen` low) while in XFER0/XFER1:
  - `ramREN`/`ramWEN` drop combinationally.
  - Next state is IDLE; `rr_ptr` advances; no wait strobe is issued.
- Requesters must hold `addr`, `store` and `burst` stable from request assertion until their last `req_wait` low.
- Non-granted requesters see `req_wait=1` and `req_load=0` at all times.

## Timing
- Reset (RST high at an edge) forces the following, and also aborts any transfer in progress:
  - state=IDLE, `rr_ptr=0`, `grant_id=0`, `grant_valid=0`.
  - `req_wait` all 1, `req_load` 0, `ramREN`/`ramWEN` 0, `ramaddr` 0, `ramstore` 0.
- Request seen in IDLE at cycle N: RAM enables asserted in N+1. The earliest `req_wait` low is in N+1, when ACCESS arrives in the same cycle.
- Each word completes in the cycle ACCESS is observed. There is no extra pipeline stage.
- There is one mandatory IDLE cycle between consecutive grants, so back-to-back grants are at least 1 cycle apart.
- `grant_valid` = (state != IDLE). It is registered.
- RAM outputs are combinational from registered state and `grant_id`, plus the live request inputs of the granted requester.
- Fairness: with all NREQ requesting continuously, each requester is granted once per NREQ grants.

## Configuration
- `RAM_ARB_WRITE_PRIO_EN` defined:
  - In IDLE, if any requester has `req_wen` high, the round-robin scan covers write requesters only. Reads are considered only when no write is pending.
  - `rr_ptr` is shared between both classes.
- Not defined: pure round-robin over all pending requests, ignoring direction.

## Test plan
- Single read: requester 2 has `req_ren`, `addr=0x100`, `burst=0`; RAM returns ACCESS 3 cycles later with `ramload=0xDEADBEEF` -> `ramREN=1`, `ramaddr=0x100`, `req_wait[2]` low for exactly 1 cycle, `req_load[2]=0xDEADBEEF`, back to IDLE, `rr_ptr=3`.
- Burst write: requester 0 has `wen`, `burst=1`, `addr=0x200`, `store=0x11` -> `ramaddr` is 0x200 then 0x204, `ramWEN=1` for both words, two separate `req_wait[0]` low pulses.
- Fairness: all 4 requesters hold `ren` with ACCESS every cycle, from reset -> grant order 0,1,2,3,0. Each word completes every 2 cycles (grant + IDLE).
- Contention with `RAM_ARB_WRITE_PRIO_EN`: `rr_ptr=0`, req0 read, req3 write -> req3 is granted first. Without the macro, req0 is granted first.
- Withdraw: req1 is granted and `ramstate` stays BUSY; req1 drops `ren` -> RAM enables drop the same cycle, IDLE next cycle, no `req_wait` low pulse.
- Reset mid-burst: RST asserted in XFER1 -> next edge all outputs at reset values, `grant_valid=0`, `rr_ptr=0`.
